// File: rtl/hack_fetch.sv
// hack_fetch: Hack instruction-fetch stage; issues pc_out to a 1-cycle ROM, buffers
// address-tagged words in a small FIFO, and drives the PC hold/redirect controls.
module hack_fetch #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_out,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_tag [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_addr;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [CW-1:0]     w_occ;
  assign instr_valid = r_count != '0;
  assign instr       = instr_valid ? r_data[r_head] : '0;
  assign instr_addr  = instr_valid ? r_tag[r_head] : '0;
  assign w_pop       = instr_valid & instr_ready;
  // occupancy counts the in-flight ROM read so a returning word always has a slot
  assign w_occ       = r_count + CW'(r_inflight) - CW'(w_pop);
  assign w_issue     = !reset & !jump & (w_occ < CW'(DEPTH));
  assign w_push      = r_inflight & !jump & !reset;
  assign rom_addr    = pc_out;
  assign pc_load     = !reset & !w_issue;
  assign pc_in       = (!reset & jump) ? jump_addr : pc_out;
  always_ff @(posedge clk) begin
    if (reset || jump) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else begin
      r_head     <= r_head + PW'(w_pop);
      r_tail     <= r_tail + PW'(w_push);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_inflight <= w_issue;
      if (w_issue)
        r_inflight_addr <= pc_out;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_tail] <= rom_data;
      r_tag[r_tail]  <= r_inflight_addr;
    end
  end
endmodule
